poly_result_bcd: RTL and testbench

Sequential binary-to-BCD converter that sits directly downstream of the polynomial evaluator. It takes the 8-bit `data_result` and produces three packed BCD digits (hundreds/tens/ones) for decimal display on HEX2..HEX0. Conversion is iterative shift-add-3 (double dabble), one bit per clock, with a start/busy/done handshake.

---
 rtl/poly_result_bcd.sv | 109 ++++++++++
 tb/tb_poly_result_bcd.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/poly_result_bcd.sv
// poly_result_bcd: iterative binary-to-BCD converter (double dabble, one
// input bit per clock) with a start/busy/done handshake. Produces three
// packed BCD digits {hundreds, tens, ones} for the HEX2..HEX0 displays.
//
// Optional feature macro: POLY_BCD_SIGNED_EN
//   defined   - bin_in is two's complement; the magnitude is converted and
//               the sign is reported on neg alongside bcd_out.
//   undefined - bin_in is unsigned and neg is always 0.
module poly_result_bcd #(
    parameter int WIDTH = 8  // 1..9 so the result always fits in 3 digits
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] bin_in,
    output logic             busy,
    output logic             done,
    output logic [11:0]      bcd_out,
    output logic             neg
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] bin_q;     // binary bits still to be shifted in
    logic [WIDTH-1:0] bin_d;
    logic [11:0]      scr_q;     // BCD scratch digits being built
    logic [11:0]      scr_adj;
    logic [11:0]      scr_d;
    logic [CW-1:0]    cnt_q;     // shifts remaining
    logic [11:0]      bcd_q;
    logic             sign_q;    // sign captured at acceptance, pending
    logic             neg_q;

    logic [WIDTH-1:0] load_val;
    logic             load_sign;

`ifdef POLY_BCD_SIGNED_EN
    // Two's complement input: convert the magnitude. The most negative value
    // negates to itself, which read as unsigned is exactly its magnitude.
    assign load_sign = bin_in[WIDTH-1];
    assign load_val  = load_sign ? (-bin_in) : bin_in;
`else
    // Unsigned input: no sign ever reported.
    assign load_sign = 1'b0;
    assign load_val  = bin_in;
`endif

    // One double-dabble step: add 3 to every digit >= 5, then shift left by one.
    always_comb begin
        scr_adj = scr_q;
        for (int d = 0; d < 3; d++) begin
            if (scr_q[4*d +: 4] >= 4'd5)
                scr_adj[4*d +: 4] = scr_q[4*d +: 4] + 4'd3;
        end
        scr_d = {scr_adj[10:0], bin_q[WIDTH-1]};
        bin_d = bin_q << 1;
    end

    // Control FSM plus datapath registers; results commit only on the last shift.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            bin_q   <= '0;
            scr_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            sign_q  <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        bin_q   <= load_val;
                        sign_q  <= load_sign;
                        scr_q   <= '0;
                        cnt_q   <= CW'(WIDTH);
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    scr_q <= scr_d;
                    bin_q <= bin_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        bcd_q   <= scr_d;
                        neg_q   <= sign_q;
                        state_q <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Handshake outputs decode straight from the state register.
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign bcd_out = bcd_q;
    assign neg     = neg_q;

endmodule

// File: tb/tb_poly_result_bcd.sv
// Testbench for poly_result_bcd (WIDTH=8). Reference model converts with
// integer division; build with +define+POLY_BCD_SIGNED_EN for signed mode.
module tb_poly_result_bcd;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  bin_in = 8'h00;
    logic        busy, done, neg;
    logic [11:0] bcd_out;

    int tests = 0;
    int fails = 0;

    poly_result_bcd #(.WIDTH(8)) dut (
        .clk(clk), .resetn(resetn), .start(start), .bin_in(bin_in),
        .busy(busy), .done(done), .bcd_out(bcd_out), .neg(neg)
    );

    always #5 clk = ~clk;

    // Returns {neg, hundreds, tens, ones} for an 8-bit input.
    function automatic logic [12:0] model(input logic [7:0] v);
        int   n;
        logic s;
        n = int'(v);
        s = 1'b0;
`ifdef POLY_BCD_SIGNED_EN
        if (n >= 128) begin n = 256 - n; s = 1'b1; end
`endif
        return {s, 4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    // Runs one conversion from a negedge; reports done seen, edges to done,
    // busy cycles, and whether bcd_out held its old value while busy.
    task automatic do_conv(input logic [7:0] v, output bit got, output int lat,
                           output int busy_n, output bit hold_ok);
        logic [11:0] prev;
        prev = bcd_out; got = 0; lat = 0; busy_n = 0; hold_ok = 1;
        bin_in = v; start = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (i == 0) begin start = 1'b0; bin_in = 8'($urandom); end
            if (busy) busy_n++;
            if (done) got = 1;
            else begin
                lat++;
                if (bcd_out !== prev) hold_ok = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        #2;
        tests++; if (bcd_out !== 12'h000) begin fails++; $display("FAIL reset_bcd: got %h want 000", bcd_out); end
        tests++; if (neg !== 1'b0)  begin fails++; $display("FAIL reset_neg: got %b want 0", neg); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
        @(negedge clk); @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        bit got, hold; int lat, bn;
        do_conv(8'h1B, got, lat, bn, hold);
        tests++; if (!got) begin fails++; $display("FAIL basic_timeout: no done within bound"); end
        tests++; if (lat != 8) begin fails++; $display("FAIL basic_latency: got %0d want 8", lat); end
        tests++; if (bn != 9) begin fails++; $display("FAIL basic_busy_cycles: got %0d want 9", bn); end
        tests++; if (bcd_out !== 12'h027) begin fails++; $display("FAIL basic_bcd: got %h want 027", bcd_out); end
        tests++; if (neg !== 1'b0) begin fails++; $display("FAIL basic_neg: got %b want 0", neg); end
        tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL basic_idle: busy %b done %b want 0 0", busy, done); end
    endtask

    task automatic test_table;
        logic [7:0]  vin  [3];
        logic [11:0] vbcd [3];
        logic        vneg [3];
        bit got, hold; int lat, bn;
`ifdef POLY_BCD_SIGNED_EN
        vin = '{8'hFF, 8'h80, 8'h7F}; vbcd = '{12'h001, 12'h128, 12'h127}; vneg = '{1'b1, 1'b1, 1'b0};
`else
        vin = '{8'hFF, 8'h00, 8'h64}; vbcd = '{12'h255, 12'h000, 12'h100}; vneg = '{1'b0, 1'b0, 1'b0};
`endif
        for (int k = 0; k < 3; k++) begin
            do_conv(vin[k], got, lat, bn, hold);
            tests++; if (!got || bcd_out !== vbcd[k] || neg !== vneg[k]) begin
                fails++; $display("FAIL table_%0d: in %h got %b/%h want %b/%h", k, vin[k], neg, bcd_out, vneg[k], vbcd[k]);
            end
            tests++; if (!hold) begin fails++; $display("FAIL table_hold_%0d: bcd_out changed while busy", k); end
        end
    endtask

    task automatic test_random;
        bit got, hold; int lat, bn; logic [7:0] v; logic [12:0] exp;
        for (int k = 0; k < 16; k++) begin
            v = 8'($urandom);
            exp = model(v);
            do_conv(v, got, lat, bn, hold);
            tests++; if (!got || {neg, bcd_out} !== exp || lat != 8) begin
                fails++; $display("FAIL random_%0d: in %h got %b/%h lat %0d want %b/%h lat 8", k, v, neg, bcd_out, lat, exp[12], exp[11:0]);
            end
        end
    endtask

    task automatic test_midshift;
        logic [7:0] v; logic [12:0] exp, cap; int dcount;
        v = 8'($urandom_range(6, 250));
        exp = model(v); dcount = 0; cap = '0;
        bin_in = v; start = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
            if (i == 3) begin start = 1'b1; bin_in = 8'h05; end
            if (i == 4) start = 1'b0;
            if (done) begin dcount++; cap = {neg, bcd_out}; end
        end
        tests++; if (dcount != 1) begin fails++; $display("FAIL midshift_done_count: got %0d want 1", dcount); end
        tests++; if (cap !== exp) begin fails++; $display("FAIL midshift_bcd: in %h got %h want %h", v, cap, exp); end
    endtask

    task automatic test_back_to_back;
        int count, last; logic [12:0] exp;
        exp = model(8'h2A); count = 0; last = -1;
        bin_in = 8'h2A; start = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) begin
                count++;
                tests++; if ({neg, bcd_out} !== exp) begin fails++; $display("FAIL b2b_bcd: got %h want %h", {neg, bcd_out}, exp); end
                if (last >= 0) begin
                    tests++; if (i - last != 10) begin fails++; $display("FAIL b2b_spacing: got %0d want 10", i - last); end
                end
                last = i;
            end
        end
        start = 1'b0;
        tests++; if (count != 3) begin fails++; $display("FAIL b2b_count: got %0d want 3", count); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        bit got, hold; int lat, bn, dcount; logic [12:0] exp;
        exp = model(8'hC8); dcount = 0;
        bin_in = 8'hC8; start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
        end
        resetn = 1'b0;
        #1;
        tests++; if (bcd_out !== 12'h000 || neg !== 1'b0) begin fails++; $display("FAIL rstmid_out: got %b/%h want 0/000", neg, bcd_out); end
        tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL rstmid_hs: busy %b done %b want 0 0", busy, done); end
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        tests++; if (dcount != 0) begin fails++; $display("FAIL rstmid_no_done: got %0d pulses want 0", dcount); end
        do_conv(8'hC8, got, lat, bn, hold);
        tests++; if (!got || {neg, bcd_out} !== exp) begin fails++; $display("FAIL rstmid_reconv: got %b/%h want %b/%h", neg, bcd_out, exp[12], exp[11:0]); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_table;
        test_random;
        test_midshift;
        test_back_to_back;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
